// File: rtl/vga_text_pkg.sv
// Shared glyph geometry and derived text-grid sizes for the VGA text path.
package vga_text_pkg;

    localparam int GLYPH_W    = 4;
    localparam int GLYPH_H    = 6;
    localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;

    function automatic int cols_of(input int h_active, input int scale);
        return h_active >> (2 + scale);
    endfunction

    function automatic int cell_h_of(input int scale);
        return GLYPH_H << scale;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Parameterised shift register with a configurable reset image; keeps side-band aligned with memory latency.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= RST_VAL;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/glyph_text_renderer.sv
// Text-mode pixel sequencer: text RAM -> glyph ROM -> one pixel bit, with de/syncs delayed to match (LAT=4).
module glyph_text_renderer
    import vga_text_pkg::*;
#(
    parameter int   H_ACTIVE     = 640,
    parameter int   V_ACTIVE     = 480,
    parameter int   SCALE        = 2,
    parameter int   TEXT_AW      = 10,
    parameter int   BLINK_FRAMES = 30,
    parameter logic VSYNC_ACT    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         pix_x,
    input  logic               de_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [TEXT_AW-1:0] text_addr,
    input  logic [7:0]         text_data,
    output logic [7:0]         rom_addr,
    input  logic [23:0]        rom_q,
    input  logic [TEXT_AW-1:0] cursor_addr,
    input  logic               cursor_en,
    output logic               pixel_on,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out
);

    localparam int COLS    = cols_of(H_ACTIVE, SCALE);
    localparam int CELL_H  = cell_h_of(SCALE);
    localparam int LINE_W  = $clog2(CELL_H);
    localparam int GROW_W  = $clog2(GLYPH_H);
    localparam int GCOL_W  = $clog2(GLYPH_W);
    localparam int BIT_W   = $clog2(GLYPH_BITS);
    localparam int BLINK_W = $clog2(BLINK_FRAMES);
    localparam int SB_W    = 3 + GCOL_W + GROW_W + 1;
    localparam logic [SB_W-1:0] SB_RST = {1'b0, ~VSYNC_ACT, ~VSYNC_ACT, {(SB_W-3){1'b0}}};

    logic [TEXT_AW-1:0] row_base;
    logic [LINE_W-1:0]  line_in_cell;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_ph;
    logic               de_prev;
    logic               vs_prev;
    logic               armed;

    // armed stays low after reset until a blanking cycle is seen, so a
    // line interrupted by reset is neither drawn nor counted.
    logic de_eff;
    logic de_fall;
    logic frame_start;
    assign de_eff      = de_in & armed;
    assign de_fall     = armed & de_prev & ~de_in;
    assign frame_start = (vsync_in == VSYNC_ACT) && (vs_prev != VSYNC_ACT);

    logic [TEXT_AW-1:0] addr_next;
    logic [GROW_W-1:0]  grow_next;
    logic [GCOL_W-1:0]  gcol_next;
    logic               cur_next;
    assign addr_next = row_base + TEXT_AW'(pix_x >> (2 + SCALE));
    assign grow_next = GROW_W'(line_in_cell >> SCALE);
    assign gcol_next = pix_x[SCALE+1:SCALE];
    assign cur_next  = cursor_en & blink_ph & (addr_next == cursor_addr);

    logic [SB_W-1:0]   sb_in;
    logic [SB_W-1:0]   sb_out;
    logic              s3_de;
    logic              s3_hs;
    logic              s3_vs;
    logic [GCOL_W-1:0] s3_gcol;
    logic [GROW_W-1:0] s3_grow;
    logic              s3_cur;
    assign sb_in = {de_eff, hsync_in, vsync_in, gcol_next, grow_next, cur_next};
    assign {s3_de, s3_hs, s3_vs, s3_gcol, s3_grow, s3_cur} = sb_out;

    // Stages 1..3: side-band rides alongside text RAM and glyph ROM latency.
    vga_delay_line #(
        .WIDTH   (SB_W),
        .DEPTH   (3),
        .RST_VAL (SB_RST)
    ) u_sideband (
        .clk  (clk),
        .rst  (rst),
        .din  (sb_in),
        .dout (sb_out)
    );

    assign rom_addr = text_data;

    logic [BIT_W-1:0] bit_sel;
    assign bit_sel = BIT_W'(GLYPH_BITS - 1 - (int'(s3_grow) * GLYPH_W + int'(s3_gcol)));

    always_ff @(posedge clk) begin
        if (rst) begin
            text_addr    <= '0;
            row_base     <= '0;
            line_in_cell <= '0;
            blink_cnt    <= '0;
            blink_ph     <= 1'b0;
            de_prev      <= 1'b0;
            vs_prev      <= ~VSYNC_ACT;
            armed        <= 1'b0;
            pixel_on     <= 1'b0;
            de_out       <= 1'b0;
            hsync_out    <= ~VSYNC_ACT;
            vsync_out    <= ~VSYNC_ACT;
        end else begin
            de_prev <= de_in;
            vs_prev <= vsync_in;
            armed   <= armed | ~de_in;

            // Frame start has priority over a coincident end of line.
            if (frame_start) begin
                row_base     <= '0;
                line_in_cell <= '0;
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else if (de_fall) begin
                if (line_in_cell == LINE_W'(CELL_H - 1)) begin
                    line_in_cell <= '0;
                    row_base     <= row_base + TEXT_AW'(COLS);
                end else begin
                    line_in_cell <= line_in_cell + 1'b1;
                end
            end

            if (de_eff) text_addr <= addr_next;

            pixel_on  <= s3_de & (rom_q[bit_sel] ^ s3_cur);
            de_out    <= s3_de;
            hsync_out <= s3_hs;
            vsync_out <= s3_vs;
        end
    end

endmodule

// File: tb/tb_glyph_text_renderer.sv
// Directed bench for glyph_text_renderer: expected pixels queued at drive time, popped on de_out.
module tb_glyph_text_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pix_x;
    logic        de_in, hsync_in, vsync_in;
    logic [9:0]  text_addr;
    logic [7:0]  text_data;
    logic [7:0]  rom_addr;
    logic [23:0] rom_q;
    logic [9:0]  cursor_addr;
    logic        cursor_en;
    logic        pixel_on, de_out, hsync_out, vsync_out;

    always #5 clk = ~clk;

    glyph_text_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .pix_x       (pix_x),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .text_addr   (text_addr),
        .text_data   (text_data),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .cursor_addr (cursor_addr),
        .cursor_en   (cursor_en),
        .pixel_on    (pixel_on),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    // Synchronous text RAM and glyph ROM, one clock of read latency each.
    logic [7:0]  tram [1024];
    logic [23:0] grom [256];
    always @(posedge clk) begin
        text_data <= tram[text_addr];
        rom_q     <= grom[rom_addr];
    end

    logic [0:0] exp_q[$];
    logic [2:0] hist_q[$];
    int         checks = 0;
    int         errors = 0;
    logic       armed_m = 1'b0;
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One input cycle; also checks {de,hs,vs} outputs against the copy driven four cycles ago.
    task automatic step(input logic r, input logic de, input logic hs, input logic vs,
                        input logic [9:0] x, input logic pix);
        logic [2:0] h;
        @(negedge clk);
        if (hist_q.size() == 4) begin
            h = hist_q.pop_front();
            check("sync_delay", {29'd0, de_out, hsync_out, vsync_out}, {29'd0, h});
        end
        rst = r; de_in = de; hsync_in = hs; vsync_in = vs; pix_x = x;
        if (r) begin
            hist_q.delete();
            exp_q.delete();
            repeat (4) hist_q.push_back(3'b011);
            armed_m = 1'b0;
        end else begin
            hist_q.push_back({de & armed_m, hs, vs});
            if (de & armed_m) exp_q.push_back(pix);
            armed_m = armed_m | ~de;
        end
        mon_en = 1'b1;
    endtask

    task automatic hblank();
        step(0, 0, 1, 1, 10'd0, 0);
        step(0, 0, 0, 1, 10'd0, 0);
        step(0, 0, 0, 1, 10'd0, 0);
        step(0, 0, 1, 1, 10'd0, 0);
    endtask

    task automatic vpulse();
        step(0, 0, 1, 0, 10'd0, 0);
        step(0, 0, 1, 0, 10'd0, 0);
        step(0, 0, 1, 1, 10'd0, 0);
        step(0, 0, 1, 1, 10'd0, 0);
    endtask

    // Cell row 0: char 0x41 (F00000, top glyph row solid), char 0x00 blank,
    // char 0x42 (842184, one lit column per glyph row: column == row % 4).
    function automatic logic exp_row0(input int line, input int x);
        int r;
        int g;
        r = line >> 2;
        g = (x >> 2) & 3;
        if (x < 16) return (r == 0);
        if (x < 32) return 1'b0;
        return (g == (r % 4));
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (de_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_unexpected actual=de_out_high required=no_pixel at %0t", $time);
                end else begin
                    check("pixel_on", {31'd0, pixel_on}, {31'd0, exp_q.pop_front()});
                end
            end else begin
                check("pixel_blank", {31'd0, pixel_on}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) tram[i] = 8'h00;
        for (int i = 0; i < 256; i++) grom[i] = 24'h0;
        tram[0] = 8'h41; tram[1] = 8'h00; tram[2] = 8'h42;
        grom[8'h41] = 24'hF00000;
        grom[8'h42] = 24'h842184;
        cursor_en = 1'b0; cursor_addr = 10'd0;
        rst = 1'b1; de_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; pix_x = 10'd0;

        // Reset held 5 clk mid-line, then released mid-line: everything stays blank.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 1, 10'(100 + i * 4), 0);
            if (i > 0) check("text_addr_in_reset", {22'd0, text_addr}, 32'd0);
        end
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 1, 1, 10'(120 + i * 4), 0);
            check("text_addr_after_reset", {22'd0, text_addr}, 32'd0);
        end
        hblank();
        hblank();

        // Frame start, then cell row 0 glyph patterns on lines 0..23.
        vpulse();
        for (int l = 0; l < 24; l++) begin
            for (int x = 0; x < 48; x++) begin
                step(0, 1, 1, 1, 10'(x), exp_row0(l, x));
                if (l == 0 && x == 17) check("text_addr_cell1", {22'd0, text_addr}, 32'd1);
                if (l == 23 && x == 33) check("text_addr_cell2", {22'd0, text_addr}, 32'd2);
            end
            hblank();
        end

        // Lines 24..99: blank cells; row_base steps by 40 every 24 lines.
        for (int l = 24; l < 100; l++) begin
            for (int x = 0; x < 96; x += 4) begin
                step(0, 1, 1, 1, 10'(x), 0);
                if (l == 24 && x == 4)  check("text_addr_l24",  {22'd0, text_addr}, 32'd40);
                if (l == 72 && x == 84) check("text_addr_l72",  {22'd0, text_addr}, 32'd125);
                if (l == 99 && x == 4)  check("text_addr_l99",  {22'd0, text_addr}, 32'd160);
            end
            if (l < 99) hblank();
        end

        // de fall coincident with vsync fall: frame start wins.
        step(0, 0, 1, 0, 10'd0, 0);
        step(0, 0, 1, 0, 10'd0, 0);
        step(0, 0, 1, 1, 10'd0, 0);
        step(0, 0, 1, 1, 10'd0, 0);
        for (int x = 0; x < 32; x++) begin
            step(0, 1, 1, 1, 10'(x), exp_row0(0, x));
            if (x == 1)  check("text_addr_frame0", {22'd0, text_addr}, 32'd0);
            if (x == 17) check("text_addr_frame1", {22'd0, text_addr}, 32'd1);
        end
        hblank();
        hblank();

        // Random de/hsync/vsync over all-blank text: outputs are 4-clk copies.
        tram[0] = 8'h00; tram[2] = 8'h00;
        for (int i = 0; i < 300; i++)
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 10'($urandom_range(0, 639)), 0);
        hblank();
        hblank();

        // Cursor blink at cell 0: off frames 0..29, on 30..59, off again from 60.
        cursor_en = 1'b1;
        cursor_addr = 10'd0;
        step(1, 0, 1, 1, 10'd0, 0);
        step(1, 0, 1, 1, 10'd0, 0);
        hblank();
        for (int f = 0; f < 62; f++) begin
            if (f > 0) vpulse();
            for (int x = 0; x < 32; x++)
                step(0, 1, 1, 1, 10'(x), (x < 16) && (f >= 30) && (f < 60));
            step(0, 0, 1, 1, 10'd0, 0);
        end
        hblank();
        hblank();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
